// File: rtl/z80_busctrl.sv
`default_nettype none
// ============================================================================
// z80_busctrl : Z80 I/O bus controller with synchronised strobes, banking
//               registers and combinational read-back for the shared data bus
// Revision    : 1.0
// ============================================================================
module z80_busctrl #(
  parameter logic [7:0] IO_BASE     = 8'hF0,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bus_a,
  input  logic [7:0]  bus_wrdata,
  input  logic        bus_rd_n,
  input  logic        bus_wr_n,
  input  logic        bus_mreq_n,
  input  logic        bus_iorq_n,
  input  logic        bus_m1_n,
  output logic [7:0]  bus_rddata,
  output logic        bus_d_oe,
  output logic [4:0]  bus_ba,
  output logic        bus_wp,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wrdata,
  output logic        io_wr,
  output logic        io_rd,
  input  logic        io_sel,
  input  logic [7:0]  io_rddata
);

  typedef enum logic [1:0] {
    ST_ARMING = 2'd0,
    ST_IDLE   = 2'd1,
    ST_WR_ACT = 2'd2,
    ST_RD_ACT = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_wr_sync;
  logic [SYNC_STAGES-1:0] r_rd_sync;
  logic [7:0]             r_bank [4];
  logic                   w_iowr_raw;
  logic                   w_iord_raw;
  logic                   w_wr_s;
  logic                   w_rd_s;
  logic                   w_quiet;
  logic                   w_wr_fire;
  logic                   w_rd_fire;
  logic                   w_rd_enter;
  logic                   w_bank_hit;
  logic                   w_unused_ok;

  assign w_iowr_raw = !bus_iorq_n && !bus_wr_n && bus_rd_n && bus_m1_n;
  assign w_iord_raw = !bus_iorq_n && !bus_rd_n && bus_wr_n && bus_m1_n;
  assign w_wr_s     = r_wr_sync[SYNC_STAGES-1];
  assign w_rd_s     = r_rd_sync[SYNC_STAGES-1];
  // A strobe still travelling through the synchroniser belongs to a cycle
  // that started before reset release, so arming waits for the whole chain.
  assign w_quiet    = !(|{r_wr_sync, r_rd_sync, w_iowr_raw, w_iord_raw});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_sync <= '0;
      r_rd_sync <= '0;
    end else begin
      r_wr_sync <= {r_wr_sync[SYNC_STAGES-2:0], w_iowr_raw};
      r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], w_iord_raw};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_fire   = 1'b0;
    w_rd_fire   = 1'b0;
    w_rd_enter  = 1'b0;
    case (r_state)
      ST_ARMING: if (w_quiet) w_state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (w_wr_s && !w_rd_s) begin
          w_state_nxt = ST_WR_ACT;
          w_wr_fire   = 1'b1;
        end else if (w_rd_s && !w_wr_s) begin
          w_state_nxt = ST_RD_ACT;
          w_rd_enter  = 1'b1;
        end
      end
      ST_WR_ACT: if (!w_wr_s) w_state_nxt = ST_IDLE;
      ST_RD_ACT: begin
        if (!w_rd_s) begin
          w_state_nxt = ST_IDLE;
          w_rd_fire   = 1'b1;
        end
      end
      default: w_state_nxt = ST_ARMING;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_ARMING;
      io_wr     <= 1'b0;
      io_rd     <= 1'b0;
      io_addr   <= 8'h00;
      io_wrdata <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      io_wr   <= w_wr_fire;
      io_rd   <= w_rd_fire;
      if (w_wr_fire || w_rd_enter) io_addr <= bus_a[7:0];
      if (w_wr_fire) io_wrdata <= bus_wrdata;
    end
  end

  // Banks load on the same edge that raises io_wr, from the address being latched.
  generate
    for (genvar n = 0; n < 4; n++) begin : g_bank
      localparam logic [7:0] c_addr = IO_BASE + 8'(n);
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_bank[n] <= 8'(n);
        end else if (w_wr_fire && bus_a[7:0] == c_addr) begin
          r_bank[n] <= bus_wrdata;
        end
      end
    end
  endgenerate

  assign bus_ba     = r_bank[bus_a[15:14]][4:0];
  assign bus_wp     = r_bank[bus_a[15:14]][7];
  assign w_bank_hit = (bus_a[7:2] == IO_BASE[7:2]) && w_iord_raw;
  assign bus_rddata = w_bank_hit ? r_bank[bus_a[1:0]] : io_rddata;
  assign bus_d_oe   = w_iord_raw && (w_bank_hit || io_sel);

  assign w_unused_ok = ^{bus_a[13:8], bus_mreq_n};

endmodule
`default_nettype wire

// File: tb/tb_z80_busctrl.sv
`default_nettype none
// ============================================================================
// tb_z80_busctrl : transaction-level bench for z80_busctrl
// Revision       : 1.0
// ============================================================================
module tb_z80_busctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] bus_a;
  logic [7:0]  bus_wrdata;
  logic        bus_rd_n, bus_wr_n, bus_mreq_n, bus_iorq_n, bus_m1_n;
  logic [7:0]  bus_rddata;
  logic        bus_d_oe;
  logic [4:0]  bus_ba;
  logic        bus_wp;
  logic [7:0]  io_addr, io_wrdata;
  logic        io_wr, io_rd;
  logic        io_sel;
  logic [7:0]  io_rddata;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;

  // Reference state: the four bank registers as the Z80 program sees them.
  logic [7:0] m_bank [4];

  z80_busctrl #(.IO_BASE(8'hF0), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus_a(bus_a), .bus_wrdata(bus_wrdata),
    .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n), .bus_mreq_n(bus_mreq_n),
    .bus_iorq_n(bus_iorq_n), .bus_m1_n(bus_m1_n), .bus_rddata(bus_rddata),
    .bus_d_oe(bus_d_oe), .bus_ba(bus_ba), .bus_wp(bus_wp), .io_addr(io_addr),
    .io_wrdata(io_wrdata), .io_wr(io_wr), .io_rd(io_rd), .io_sel(io_sel),
    .io_rddata(io_rddata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (io_wr === 1'b1) wr_cnt++;
    if (io_rd === 1'b1) rd_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_bank[i] = 8'(i);
  endtask

  task automatic bus_idle();
    bus_rd_n = 1'b1; bus_wr_n = 1'b1; bus_mreq_n = 1'b1;
    bus_iorq_n = 1'b1; bus_m1_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic bit is_bank(input logic [7:0] lo);
    return (lo >= 8'hF0) && (lo <= 8'hF3);
  endfunction

  task automatic io_out(input logic [15:0] a, input logic [7:0] d, input int gap);
    int w0;
    w0 = wr_cnt;
    bus_a = a; bus_wrdata = d; bus_iorq_n = 1'b0; bus_wr_n = 1'b0;
    step(10);
    bus_idle();
    step(gap);
    if (is_bank(a[7:0])) m_bank[a[1:0]] = d;
    check("out_wr_pulses", 16'(wr_cnt - w0), 16'd1);
    check("out_io_addr", {8'h0, io_addr}, {8'h0, a[7:0]});
    check("out_io_wrdata", {8'h0, io_wrdata}, {8'h0, d});
  endtask

  task automatic io_in(input logic [15:0] a, input logic sel, input logic [7:0] ext);
    int r0, w0;
    logic [7:0] exp_d;
    logic       exp_oe;
    r0 = rd_cnt; w0 = wr_cnt;
    bus_a = a; io_sel = sel; io_rddata = ext;
    bus_iorq_n = 1'b0; bus_rd_n = 1'b0;
    exp_oe = is_bank(a[7:0]) || sel;
    exp_d  = is_bank(a[7:0]) ? m_bank[a[1:0]] : ext;
    step(2);
    @(negedge clk);
    check("in_oe", {15'h0, bus_d_oe}, {15'h0, exp_oe});
    check("in_rddata", {8'h0, bus_rddata}, {8'h0, exp_d});
    step(8);
    check("in_no_early_rd", 16'(rd_cnt - r0), 16'd0);
    bus_idle();
    step(6);
    check("in_oe_after", {15'h0, bus_d_oe}, 16'd0);
    check("in_rd_pulses", 16'(rd_cnt - r0), 16'd1);
    check("in_wr_pulses", 16'(wr_cnt - w0), 16'd0);
    check("in_io_addr", {8'h0, io_addr}, {8'h0, a[7:0]});
    io_sel = 1'b0;
  endtask

  // Non-I/O activity: interrupt acknowledge (kind 0) or memory write (kind 1).
  task automatic non_io(input int kind, input logic [15:0] a, input logic [7:0] d);
    int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    bus_a = a; bus_wrdata = d;
    if (kind == 0) begin
      bus_m1_n = 1'b0; bus_iorq_n = 1'b0;
    end else begin
      bus_mreq_n = 1'b0; bus_wr_n = 1'b0;
    end
    step(2);
    @(negedge clk);
    check("nonio_oe", {15'h0, bus_d_oe}, 16'd0);
    step(8);
    bus_idle();
    step(6);
    check("nonio_wr", 16'(wr_cnt - w0), 16'd0);
    check("nonio_rd", 16'(rd_cnt - r0), 16'd0);
  endtask

  task automatic sweep_banks();
    for (int q = 0; q < 4; q++) begin
      bus_a = {2'(q), 14'h0};
      #1;
      check("sweep_ba", {11'h0, bus_ba}, {11'h0, m_bank[q][4:0]});
      check("sweep_wp", {15'h0, bus_wp}, {15'h0, m_bank[q][7]});
    end
  endtask

  initial begin
    int w0;
    reset_n = 1'b0; bus_a = 16'hC000; bus_wrdata = 8'h00;
    io_sel = 1'b0; io_rddata = 8'h00;
    bus_idle();
    model_reset();
    step(3);
    check("rst_oe", {15'h0, bus_d_oe}, 16'd0);
    check("rst_io_wr", {15'h0, io_wr}, 16'd0);
    check("rst_io_rd", {15'h0, io_rd}, 16'd0);
    check("rst_io_addr", {8'h0, io_addr}, 16'd0);
    check("rst_io_wrdata", {8'h0, io_wrdata}, 16'd0);
    check("rst_ba", {11'h0, bus_ba}, 16'd3);
    check("rst_wp", {15'h0, bus_wp}, 16'd0);
    reset_n = 1'b1;
    step(4);

    io_in(16'h00F2, 1'b0, 8'hEE);
    io_in(16'h0010, 1'b0, 8'h77);
    io_in(16'h0010, 1'b1, 8'h5A);
    io_out(16'h12F1, 8'h85, 6);
    sweep_banks();
    non_io(0, 16'h00F0, 8'hFF);
    non_io(1, 16'h00F0, 8'hFF);
    sweep_banks();

    // Reset released in the middle of an OUT: that cycle must be discarded.
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_clr_addr", {8'h0, io_addr}, 16'd0);
    check("async_clr_wrdata", {8'h0, io_wrdata}, 16'd0);
    bus_a = 16'h00F3; bus_wrdata = 8'h77; bus_iorq_n = 1'b0; bus_wr_n = 1'b0;
    step(2);
    w0 = wr_cnt;
    reset_n = 1'b1;
    step(8);
    bus_idle();
    step(8);
    check("armed_no_wr", 16'(wr_cnt - w0), 16'd0);
    sweep_banks();
    io_out(16'h00F3, 8'hA4, 6);

    for (int i = 0; i < 4; i++) io_out({8'h00, 8'hF0 + 8'(i)}, 8'h10 + 8'(i), 4);
    sweep_banks();

    for (int i = 0; i < 40; i++) begin
      logic [7:0]  lo;
      logic [15:0] a;
      lo = ($urandom_range(0, 1) == 1) ? 8'hF0 + 8'($urandom_range(0, 3)) : 8'($urandom);
      a  = {8'($urandom), lo};
      case ($urandom_range(0, 3))
        0: io_out(a, 8'($urandom), 4 + $urandom_range(0, 3));
        1: io_in(a, 1'($urandom), 8'($urandom));
        default: non_io($urandom_range(0, 1), a, 8'($urandom));
      endcase
      if (i % 8 == 7) sweep_banks();
    end
    sweep_banks();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
